// File: rtl/mem_scrub.sv
// -----------------------------------------------------------------------------
// mem_scrub
//   Scrubber for a parity-protected memory that stores DATA_W data bits plus
//   one parity bit. It walks an address range, reads each word and checks that
//   the top bit equals the XOR of the data bits. Errors are reported with their
//   address and the raw word. When fix_en was set at start, the data byte is
//   written back so the memory regenerates correct parity.
//
// Ports
//   clk, rst       clock (rising edge), synchronous active-high reset
//   start          begin a pass (only honoured in IDLE)
//   base_addr      first address of the pass, captured on start
//   count          number of locations, captured on start
//   fix_en         rewrite bad locations, captured on start
//   mem_write      memory write strobe
//   mem_read       memory read strobe
//   mem_address    memory address (driven in ISSUE and FIX, 0 otherwise)
//   mem_data_in    byte to rewrite (memory appends parity)
//   mem_rdata      memory read word, valid the cycle after mem_read
//   busy           pass in progress (ISSUE, CHECK, FIX)
//   done           one-cycle pulse at the end of a pass
//   err_valid      one-cycle pulse per detected parity error
//   err_addr       address of the error, valid with err_valid
//   err_data       raw word read, valid with err_valid
//   err_count      saturating error count for the current/last pass
//   state_dbg      current FSM state encoding, for observation only
//
// Handshake: there is none on the memory side. mem_read is a one-cycle strobe
// and the word is consumed exactly one cycle later; mem_write is a one-cycle
// strobe. The two strobes are never high together.
// -----------------------------------------------------------------------------
module mem_scrub #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              fix_en,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W:0]   mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W:0]   err_data,
  output logic [CNT_W-1:0]  err_count,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_CHECK = 3'd2,
    S_FIX   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [CNT_W-1:0]  remaining;
  logic              fix_q;
  logic [DATA_W-1:0] fix_byte;
  logic              parity_bad;
  logic              last_loc;

  // Stored parity must equal the XOR of the data bits.
  assign parity_bad = mem_rdata[DATA_W] ^ (^mem_rdata[DATA_W-1:0]);
  assign last_loc   = (remaining == CNT_ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      fix_q     <= 1'b0;
      fix_byte  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= count;
            fix_q     <= fix_en;
            err_count <= '0;
            state     <= (count == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: state <= S_CHECK;
        S_CHECK: begin
          // Keep the byte so FIX can write it back after mem_rdata moves on.
          fix_byte <= mem_rdata[DATA_W-1:0];
          if (parity_bad && (err_count != '1)) begin
            err_count <= err_count + CNT_ONE;
          end
          if (parity_bad && fix_q) begin
            state <= S_FIX;
          end else begin
            cur_addr  <= cur_addr + ADDR_ONE;
            remaining <= remaining - CNT_ONE;
            state     <= last_loc ? S_DONE : S_ISSUE;
          end
        end
        S_FIX: begin
          cur_addr  <= cur_addr + ADDR_ONE;
          remaining <= remaining - CNT_ONE;
          state     <= last_loc ? S_DONE : S_ISSUE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state. Strobes are also masked by rst so a
  // reset landing on an ISSUE/FIX cycle cannot touch the memory.
  always_comb begin
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    busy        = 1'b0;
    done        = 1'b0;
    err_valid   = 1'b0;
    err_addr    = '0;
    err_data    = '0;
    case (state)
      S_ISSUE: begin
        busy        = 1'b1;
        mem_read    = !rst;
        mem_address = cur_addr;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (parity_bad) begin
          err_valid = 1'b1;
          err_addr  = cur_addr;
          err_data  = mem_rdata;
        end
      end
      S_FIX: begin
        busy        = 1'b1;
        mem_write   = !rst;
        mem_address = cur_addr;
        mem_data_in = fix_byte;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_scrub.sv
// -----------------------------------------------------------------------------
// tb_mem_scrub
//   Directed bench for mem_scrub with a behavioural parity memory model.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_scrub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] count;
  logic        fix_en;
  logic        mem_write;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [8:0]  mem_rdata = '0;
  logic        busy;
  logic        done;
  logic        err_valid;
  logic [15:0] err_addr;
  logic [8:0]  err_data;
  logic [15:0] err_count;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_q[$];
  logic [8:0]  mem [0:65535];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mem_scrub #(.ADDR_W(16), .DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .count(count), .fix_en(fix_en), .mem_write(mem_write),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_rdata(mem_rdata), .busy(busy),
    .done(done), .err_valid(err_valid), .err_addr(err_addr),
    .err_data(err_data), .err_count(err_count), .state_dbg(state_dbg)
  );

  // Memory model: read data appears the cycle after mem_read; a write stores
  // the byte with freshly generated parity (bit 8 = XOR of bits 7:0).
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem[mem_address];
    if (mem_write) mem[mem_address] = {^mem_data_in, mem_data_in};
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] addr, input logic [7:0] b);
    mem[addr] = {^b, b};
  endtask

  // Presents start for one cycle; returns at the falling edge of cycle 1.
  task automatic start_pass(input logic [15:0] b, input logic [15:0] c, input logic f);
    start = 1'b1; base_addr = b; count = c; fix_en = f;
    tick();
    start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n_reads;
    logic seen_done;

    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; fix_en = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 9'h000;
    tick(); tick();

    // Reset state
    check("rst_read",   mem_read,    0);
    check("rst_write",  mem_write,   0);
    check("rst_busy",   busy,        0);
    check("rst_done",   done,        0);
    check("rst_errv",   err_valid,   0);
    check("rst_errcnt", err_count,   0);
    check("rst_addr",   mem_address, 0);
    check("rst_state",  state_dbg,   0);
    rst = 1'b0;
    tick();

    // Clean pass of four locations: reads on odd cycles, done at cycle 9
    preload(16'h0100, 8'h11);
    preload(16'h0101, 8'h22);
    preload(16'h0102, 8'h37);
    preload(16'h0103, 8'hFF);
    start_pass(16'h0100, 16'd4, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      check("clean_read", mem_read, (c % 2 == 1) && (c < 9));
      if ((c % 2 == 1) && (c < 9))
        check("clean_addr", mem_address, 32'h0100 + (c - 1) / 2);
      check("clean_done", done, c == 9);
      check("clean_busy", busy, c < 9);
      check("clean_errv", err_valid, 0);
      check("clean_write", mem_write, 0);
      tick();
    end
    check("clean_errcnt", err_count, 0);
    check("clean_idle", state_dbg, 0);

    // Bad word with fix: 0x1A5 has parity 1 but XOR(0xA5) is 0
    mem[16'h0200] = 9'h1A5;
    start_pass(16'h0200, 16'd1, 1'b1);
    check("fix_c1_read", mem_read, 1);
    check("fix_c1_addr", mem_address, 16'h0200);
    tick();
    check("fix_c2_errv", err_valid, 1);
    check("fix_c2_erra", err_addr, 16'h0200);
    check("fix_c2_errd", err_data, 9'h1A5);
    check("fix_c2_read", mem_read, 0);
    tick();
    check("fix_c3_write", mem_write, 1);
    check("fix_c3_read", mem_read, 0);
    check("fix_c3_addr", mem_address, 16'h0200);
    check("fix_c3_data", mem_data_in, 8'hA5);
    check("fix_c3_errv", err_valid, 0);
    check("fix_c3_errcnt", err_count, 1);
    tick();
    check("fix_c4_done", done, 1);
    check("fix_c4_write", mem_write, 0);
    check("fix_c4_errcnt", err_count, 1);
    check("fix_mem_word", mem[16'h0200], 9'h0A5);
    tick();

    // Re-scan of the repaired word is clean
    start_pass(16'h0200, 16'd1, 1'b1);
    check("rescan_read", mem_read, 1);
    tick();
    check("rescan_errv", err_valid, 0);
    tick();
    check("rescan_done", done, 1);
    check("rescan_write", mem_write, 0);
    check("rescan_errcnt", err_count, 0);
    tick();

    // Same error without fix: report only, no write
    mem[16'h0200] = 9'h1A5;
    start_pass(16'h0200, 16'd1, 1'b0);
    tick();
    check("nofix_errv", err_valid, 1);
    check("nofix_errd", err_data, 9'h1A5);
    tick();
    check("nofix_done", done, 1);
    check("nofix_write", mem_write, 0);
    check("nofix_errcnt", err_count, 1);
    tick(); tick();
    check("nofix_hold", err_count, 1);
    check("nofix_mem", mem[16'h0200], 9'h1A5);

    // Address wrap at the top of the space
    preload(16'hFFFE, 8'h5A);
    preload(16'hFFFF, 8'h01);
    preload(16'h0000, 8'h80);
    preload(16'h0001, 8'hC3);
    exp_q.push_back(16'hFFFE);
    exp_q.push_back(16'hFFFF);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    n_reads = 0;
    seen_done = 1'b0;
    start_pass(16'hFFFE, 16'd4, 1'b0);
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      if (mem_read) begin
        n_reads++;
        if (exp_q.size() > 0) check("wrap_addr", mem_address, exp_q.pop_front());
      end
      if (done) seen_done = 1'b1;
      tick();
    end
    check("wrap_done_seen", seen_done, 1);
    check("wrap_nreads", n_reads, 4);
    check("wrap_errcnt", err_count, 0);

    // count == 0: done immediately; start held through DONE is ignored
    start = 1'b1; base_addr = 16'h0500; count = 16'd0; fix_en = 1'b1;
    tick();
    check("zero_done", done, 1);
    check("zero_busy", busy, 0);
    check("zero_read", mem_read, 0);
    check("zero_write", mem_write, 0);
    check("zero_state", state_dbg, 4);
    tick();
    check("zero_c2_idle", state_dbg, 0);
    check("zero_c2_done", done, 0);
    check("zero_c2_busy", busy, 0);
    start = 1'b0;
    tick();
    check("zero_c3_idle", state_dbg, 0);

    // Reset during the FIX cycle suppresses the write
    mem[16'h0300] = 9'h1A5;
    start_pass(16'h0300, 16'd1, 1'b1);
    tick();
    check("rstmid_errv", err_valid, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rstmid_write_gated", mem_write, 0);
    tick();
    tick();
    check("rstmid_state", state_dbg, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_write", mem_write, 0);
    check("rstmid_read", mem_read, 0);
    check("rstmid_errcnt", err_count, 0);
    check("rstmid_errv", err_valid, 0);
    check("rstmid_mem", mem[16'h0300], 9'h1A5);
    rst = 1'b0;
    tick();
    start_pass(16'h0100, 16'd1, 1'b0);
    check("after_rst_read", mem_read, 1);
    check("after_rst_addr", mem_address, 16'h0100);
    tick(); tick();
    check("after_rst_done", done, 1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
